serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder with carry-in, carry-out and signed-overflow flag, driven by a start/busy/done handshake. It is the additive counterpart to the subtractor blocks in the arithmetic library. It trades area for latency: one full-add cell plus a carry flip-flop, one operand bit per clock, LSB first. It is intended for multi-cycle datapaths where a parallel adder is not justified.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when not busy
- A  input  WIDTH  operand A, sampled with start
- B  input  WIDTH  operand B, sampled with start
- Cin  input  1  carry-in, sampled with start
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse: S/Cout/V just updated
- S  output  WIDTH  registered sum; holds last result
- Cout  output  1  carry out of bit WIDTH-1
- V  output  1  signed overflow (carry into MSB XOR Cout)

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE: start=1 at an edge loads A/B into internal shift registers, carry FF←Cin, bit counter←0. Next state is RUN.
- RUN, each edge:
  - sum bit = a0^b0^c, shifted into the MSB of the internal sum register, which shifts right.
  - c ← a0&b0 | c&(a0^b0).
  - A/B shift right; counter increments.
  - On the edge where counter = WIDTH-2 (the MSB bit is processed next), capture the current carry as carry-into-MSB.
- RUN, last bit (counter = WIDTH-1):
  - Result is written to S, Cout ← final carry, V ← carry-into-MSB ^ final carry.
  - Next state is FIN.
- FIN: done=1 for exactly this cycle. start=1 here starts a new operation identically to IDLE (next state RUN); otherwise next state is IDLE.
- busy=1 in RUN only. start while busy is ignored: no reload, no effect on the result.
- S, Cout and V change only on the completion edge. They hold their value through IDLE, FIN and any subsequent RUN until the next completion.
- Width rule: the internal sum is exactly WIDTH bits; bit WIDTH is Cout only. The counter is $clog2(WIDTH) bits and never wraps mid-operation.
- Reset (any time, including mid-RUN): state IDLE, busy=0, done=0, S=0, Cout=0, V=0; internal registers cleared. The in-flight operation is discarded and does not resume after reset is released.

## Timing
- The start edge is t0. busy=1 after t0 through the cycle ending at edge t0+WIDTH.
- S/Cout/V become valid and done=1 after edge t0+WIDTH. done falls after edge t0+WIDTH+1.
- Latency, start edge to result: WIDTH clocks.
- Back-to-back throughput: one result per WIDTH+1 clocks, with start held or re-asserted during FIN.
- A, B and Cin must be stable only at the start edge; they may change freely afterwards.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, A=0x3C, B=0x25, Cin=0, start one cycle → after 8 clocks S=0x61, Cout=0, V=0, done high for exactly one cycle, busy high for exactly 8 cycles.
- A=0xFF, B=0x01, Cin=0 → S=0x00, Cout=1, V=0. Then A=0x7F, B=0x01 → S=0x80, Cout=0, V=1. Then A=0x80, B=0x80 → S=0x00, Cout=1, V=1.
- A=0xFF, B=0xFF, Cin=1 → S=0xFF, Cout=1, V=0. Previous S value must remain visible until the completion edge.
- start pulsed again at clock 3 of a run with different A/B → ignored. The first result is unchanged and completes on time, and no second done follows.
- start held high continuously with A=0x10, B=0x01 → done pulses every 9 clocks, S=0x11 each time, no lost or extra operations.
- rst asserted asynchronously mid-clock at clock 4 of a run → outputs go to zero immediately (before the next edge), state returns to IDLE, and no done pulse occurs. A new start after release gives a correct result.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock; result WIDTH clocks after the start edge.
// No backpressure: start is accepted in IDLE/FIN and ignored while busy; done pulses once per result.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             v_q, v_d;

    logic sum_bit;
    logic carry_nxt;

    assign sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
    assign carry_nxt = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        s_d     = s_q;
        cout_d  = cout_q;
        v_d     = v_q;

        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    c_d     = Cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = carry_nxt;
                sum_d = {sum_bit, sum_q[WIDTH-1:1]};
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // c_q here is the carry into the MSB, so overflow needs no extra register
                    s_d     = {sum_bit, sum_q[WIDTH-1:1]};
                    cout_d  = carry_nxt;
                    v_d     = c_q ^ carry_nxt;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == FIN);
    assign S    = s_q;
    assign Cout = cout_q;
    assign V    = v_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         v;

    int n_assert;
    int n_fail;

    logic [W-1:0] prev_s;
    logic         prev_c;
    logic         prev_v;

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (a),
        .B    (b),
        .Cin  (cin),
        .busy (busy),
        .done (done),
        .S    (s),
        .Cout (cout),
        .V    (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition, overflow from operand and result signs.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                         output logic [W-1:0] es, output logic ec, output logic ev);
        logic [W:0] full;
        full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        es   = full[W-1:0];
        ec   = full[W];
        ev   = (ma[W-1] == mb[W-1]) && (es[W-1] != ma[W-1]);
    endtask

    // Call at a negedge with the DUT in IDLE or FIN; returns at the negedge of the done cycle.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                          input bit hold, input bit inject);
        logic [W-1:0] es;
        logic         ec;
        logic         ev;
        model(oa, ob, oc, es, ec, ev);
        start = 1'b1;
        a     = oa;
        b     = ob;
        cin   = oc;
        @(negedge clk);
        if (!hold) begin
            start = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
        end
        for (int i = 0; i < W; i++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk("s_hold", 32'(s), 32'(prev_s));
            chk("cout_hold", 32'(cout), 32'(prev_c));
            chk("v_hold", 32'(v), 32'(prev_v));
            if (inject && i == 2) begin
                start = 1'b1;
                a     = ~oa;
                b     = oa;
                cin   = ~oc;
            end
            if (inject && i == 3 && !hold) start = 1'b0;
            @(negedge clk);
        end
        chk("done_fin", 32'(done), 32'd1);
        chk("busy_fin", 32'(busy), 32'd0);
        chk("s_res", 32'(s), 32'(es));
        chk("cout_res", 32'(cout), 32'(ec));
        chk("v_res", 32'(v), 32'(ev));
        prev_s = es;
        prev_c = ec;
        prev_v = ev;
    endtask

    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("done_idle", 32'(done), 32'd0);
            chk("busy_idle", 32'(busy), 32'd0);
            chk("s_idle", 32'(s), 32'(prev_s));
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        prev_s   = '0;
        prev_c   = 1'b0;
        prev_v   = 1'b0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_v", 32'(v), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed corner sums
        run_op(8'h3C, 8'h25, 1'b0, 1'b0, 1'b0);
        chk("s_3c25", 32'(s), 32'h61);
        idle_check(2);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        idle_check(1);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        chk("v_7f01", 32'(v), 32'd1);
        idle_check(1);
        run_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        idle_check(1);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        idle_check(1);

        // start while busy must not disturb the run or add a second result
        run_op(8'h5A, 8'h33, 1'b1, 1'b0, 1'b1);
        idle_check(W + 2);

        // start held high: results every W+1 clocks, none lost
        for (int k = 0; k < 3; k++) begin
            run_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
            chk("s_held", 32'(s), 32'h11);
        end
        start = 1'b0;
        idle_check(W + 2);

        // Asynchronous reset mid-run
        start = 1'b1;
        a     = 8'hA5;
        b     = 8'h3C;
        cin   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_s", 32'(s), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        chk("arst_v", 32'(v), 32'd0);
        prev_s = '0;
        prev_c = 1'b0;
        prev_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_check(W + 2);
        chk("arst_cout_after", 32'(cout), 32'd0);
        run_op(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0);

        // Random operations, some restarted straight out of FIN
        for (int k = 0; k < 24; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);
            if ($urandom_range(0, 1) == 0) idle_check($urandom_range(1, 3));
        end
        idle_check(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
